// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Start/busy/done handshake; results hold until the next completion edge.
module conversor_bin_bcd #(
    parameter int LARGURA   = 16,
    parameter int DIGITOS   = 5,
    parameter bit COM_SINAL = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic [LARGURA-1:0]   binario,
    output logic                 ocupado,
    output logic                 pronto,
    output logic [4*DIGITOS-1:0] bcd,
    output logic                 negativo
);

    localparam int BW = 4 * DIGITOS;
    localparam int SW = BW + LARGURA;
    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic {
        OCIOSO,
        CONVERTE
    } estado_t;

    estado_t          estado, estado_prox;
    logic [SW-1:0]    registro;
    logic [SW-1:0]    ajustado;
    logic [SW-1:0]    deslocado;
    logic [CW-1:0]    contador;
    logic             sinal;
    logic [LARGURA-1:0] magnitude;
    logic             carregar;
    logic             passo;
    logic             concluir;

    always_comb begin
        magnitude = binario;
        if (COM_SINAL && binario[LARGURA-1])
            magnitude = ~binario + LARGURA'(1);
    end

    // Add 3 to every BCD digit >= 5 before the shift
    always_comb begin
        ajustado = registro;
        for (int k = 0; k < DIGITOS; k++) begin
            if (registro[LARGURA+4*k +: 4] >= 4'd5)
                ajustado[LARGURA+4*k +: 4] = registro[LARGURA+4*k +: 4] + 4'd3;
        end
        deslocado = ajustado << 1;
    end

    always_comb begin
        estado_prox = estado;
        carregar    = 1'b0;
        passo       = 1'b0;
        concluir    = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    carregar    = 1'b1;
                    estado_prox = CONVERTE;
                end
            end
            CONVERTE: begin
                passo = 1'b1;
                if (contador == CW'(1)) begin
                    concluir    = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            registro <= '0;
            contador <= '0;
            sinal    <= 1'b0;
        end else if (carregar) begin
            registro <= {{BW{1'b0}}, magnitude};
            contador <= CW'(LARGURA);
            sinal    <= COM_SINAL && binario[LARGURA-1];
        end else if (passo) begin
            registro <= deslocado;
            contador <= contador - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd      <= '0;
            negativo <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            pronto <= concluir;
            if (concluir) begin
                bcd      <= deslocado[SW-1:LARGURA];
                negativo <= sinal;
            end
        end
    end

    assign ocupado = (estado == CONVERTE);

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Bench for conversor_bin_bcd: signed and unsigned instances side by side,
// table vectors, random values against an arithmetic model, corner sequences.
module tb_conversor_bin_bcd;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic [15:0] binario = '0;

    logic        ocupado_s, pronto_s, negativo_s;
    logic [19:0] bcd_s;
    logic        ocupado_u, pronto_u, negativo_u;
    logic [19:0] bcd_u;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    conversor_bin_bcd #(.LARGURA(16), .DIGITOS(5), .COM_SINAL(1'b1)) dut_s (
        .clock(clock), .reset(reset), .iniciar(iniciar), .binario(binario),
        .ocupado(ocupado_s), .pronto(pronto_s), .bcd(bcd_s),
        .negativo(negativo_s)
    );

    conversor_bin_bcd #(.LARGURA(16), .DIGITOS(5), .COM_SINAL(1'b0)) dut_u (
        .clock(clock), .reset(reset), .iniciar(iniciar), .binario(binario),
        .ocupado(ocupado_u), .pronto(pronto_u), .bcd(bcd_u),
        .negativo(negativo_u)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd_sig;
        logic        neg_sig;
        logic [19:0] bcd_uns;
    } vetor_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Decimal digits via plain division; sign from two's complement value
    function automatic logic [19:0] ref_bcd(input logic [15:0] v,
                                            input bit sgn,
                                            output bit neg);
        logic [19:0] r;
        int m;
        m = int'(v);
        neg = 1'b0;
        if (sgn && v[15]) begin
            m = 65536 - int'(v);
            neg = 1'b1;
        end
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic convert(input logic [15:0] v, input bit noise,
                           input logic [19:0] exp_s, input bit exp_ns,
                           input logic [19:0] exp_u, input string tag);
        logic [19:0] prev_s, prev_u;
        logic        prev_ns;
        bit busy_ok, hold_ok, got;
        int cycles;
        @(negedge clock);
        binario = v;
        iniciar = 1'b1;
        prev_s  = bcd_s;
        prev_u  = bcd_u;
        prev_ns = negativo_s;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 40) begin
            if (pronto_s || pronto_u) begin
                got = 1'b1;
            end else begin
                if (!ocupado_s || !ocupado_u) busy_ok = 1'b0;
                if (bcd_s !== prev_s || bcd_u !== prev_u ||
                    negativo_s !== prev_ns || negativo_u !== 1'b0)
                    hold_ok = 1'b0;
                @(negedge clock);
                if (noise && cycles < 14) begin
                    iniciar = 1'($urandom % 2);
                    binario = 16'($urandom);
                end else begin
                    iniciar = 1'b0;
                end
                @(posedge clock);
                #1;
                cycles++;
            end
        end
        check({tag, " latency"}, cycles, 16);
        check({tag, " busy"}, {31'd0, busy_ok}, 1);
        check({tag, " hold"}, {31'd0, hold_ok}, 1);
        check({tag, " pronto both"}, {30'd0, pronto_s, pronto_u}, 3);
        check({tag, " ocupado at pronto"}, {30'd0, ocupado_s, ocupado_u}, 0);
        check({tag, " bcd signed"}, {12'd0, bcd_s}, {12'd0, exp_s});
        check({tag, " neg signed"}, {31'd0, negativo_s}, {31'd0, exp_ns});
        check({tag, " bcd unsigned"}, {12'd0, bcd_u}, {12'd0, exp_u});
        check({tag, " neg unsigned"}, {31'd0, negativo_u}, 0);
        @(posedge clock);
        #1;
        check({tag, " pronto drop"}, {30'd0, pronto_s, pronto_u}, 0);
    endtask

    vetor_t tabela[6];

    initial begin
        logic [15:0] v;
        logic [19:0] es, eu;
        bit ns, nu;
        logic [15:0] vals[60];
        int conv;
        int stray;
        bit got;
        int cycles;

        tabela[0] = '{16'd0,     20'h00000, 1'b0, 20'h00000};
        tabela[1] = '{16'd12345, 20'h12345, 1'b0, 20'h12345};
        tabela[2] = '{16'hFFFF,  20'h00001, 1'b1, 20'h65535};
        tabela[3] = '{16'h8000,  20'h32768, 1'b1, 20'h32768};
        tabela[4] = '{16'd9999,  20'h09999, 1'b0, 20'h09999};
        tabela[5] = '{16'd4321,  20'h04321, 1'b0, 20'h04321};

        repeat (3) @(posedge clock);
        #1;
        check("reset ocupado", {30'd0, ocupado_s, ocupado_u}, 0);
        check("reset pronto", {30'd0, pronto_s, pronto_u}, 0);
        check("reset bcd", {bcd_s[15:0], bcd_u[15:0]}, 0);
        check("reset neg", {30'd0, negativo_s, negativo_u}, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 6; i++)
            convert(tabela[i].bin, 1'b0, tabela[i].bcd_sig, tabela[i].neg_sig,
                    tabela[i].bcd_uns, $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            v = 16'($urandom);
            if (i == 0) v = 16'h7FFF;
            if (i == 1) v = 16'h8001;
            es = ref_bcd(v, 1'b1, ns);
            eu = ref_bcd(v, 1'b0, nu);
            convert(v, 1'b1, es, ns, eu, $sformatf("rnd%0d", i));
        end

        // iniciar held high: accepts every LARGURA+1 edges
        @(negedge clock);
        iniciar = 1'b1;
        conv = 0;
        stray = 0;
        for (int e = 0; e < 52; e++) begin
            v = 16'($urandom);
            binario = v;
            vals[e] = v;
            @(posedge clock);
            #1;
            if (e % 17 == 16) begin
                es = ref_bcd(vals[e-16], 1'b1, ns);
                eu = ref_bcd(vals[e-16], 1'b0, nu);
                check($sformatf("b2b%0d pronto", conv),
                      {30'd0, pronto_s, pronto_u}, 3);
                check($sformatf("b2b%0d bcd_s", conv), {12'd0, bcd_s},
                      {12'd0, es});
                check($sformatf("b2b%0d neg_s", conv), {31'd0, negativo_s},
                      {31'd0, ns});
                check($sformatf("b2b%0d bcd_u", conv), {12'd0, bcd_u},
                      {12'd0, eu});
                conv++;
            end else if (pronto_s || pronto_u || !ocupado_s) begin
                stray++;
            end
            @(negedge clock);
        end
        iniciar = 1'b0;
        check("b2b stray pronto or idle", stray, 0);
        repeat (20) @(posedge clock);

        // Reset 7 cycles into a conversion
        @(negedge clock);
        binario = 16'd4321;
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort ocupado", {30'd0, ocupado_s, ocupado_u}, 0);
        check("abort bcd", {bcd_s[15:0], bcd_u[15:0]}, 0);
        check("abort neg", {30'd0, negativo_s, negativo_u}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        got = 1'b0;
        cycles = 0;
        while (cycles < 25) begin
            @(posedge clock);
            #1;
            if (pronto_s || pronto_u || ocupado_s || ocupado_u) got = 1'b1;
            cycles++;
        end
        check("abort no pronto", {31'd0, got}, 0);
        convert(16'd4321, 1'b0, 20'h04321, 1'b0, 20'h04321, "after abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
